// File: rtl/dmac_request_generator.sv
// DMAC request generator: splits whole-transfer requests into 16-beat bursts,
// issues Gray-coded burst IDs against the mover's response_id and flags end-of-transfer.
module dmac_request_generator #(
  parameter int C_ID_WIDTH     = 3,
  parameter int C_BURSTS_WIDTH = 8
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  input  logic                      enable,
  output logic                      enabled,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [C_BURSTS_WIDTH-1:0] req_burst_count,
  input  logic [3:0]                req_last_burst_length,
  output logic [C_ID_WIDTH-1:0]     request_id,
  input  logic [C_ID_WIDTH-1:0]     response_id,
  output logic                      sync_id,
  output logic                      eot,
  output logic                      dm_req_valid,
  input  logic                      dm_req_ready,
  output logic [3:0]                dm_req_last_burst_length,
  output logic                      xfer_done
);

  localparam int NUM_IDS = 2 ** C_ID_WIDTH;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                    state, state_next;
  logic [C_BURSTS_WIDTH-1:0] remaining;
  logic [NUM_IDS-1:0]        eot_mem;
  logic [C_ID_WIDTH-1:0]     prev_response_id;
  logic [C_ID_WIDTH-1:0]     next_id;
  logic                      accept;
  logic                      issue;
  logic                      last_burst;
  logic                      retire;

  // Gray successor: decode to binary, add one, re-encode (wraps naturally).
  function automatic logic [C_ID_WIDTH-1:0] inc_id(input logic [C_ID_WIDTH-1:0] g);
    logic [C_ID_WIDTH-1:0] b;
    b[C_ID_WIDTH-1] = g[C_ID_WIDTH-1];
    for (int i = C_ID_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    b = b + C_ID_WIDTH'(1);
    return b ^ (b >> 1);
  endfunction

  assign next_id    = inc_id(request_id);
  assign req_ready  = enabled & ~dm_req_valid & (state == IDLE);
  assign accept     = req_valid & req_ready;
  // One slot is always left empty so a full ring is distinguishable from an empty one.
  assign issue      = (state == ISSUE) && (next_id != response_id);
  assign last_burst = (remaining == '0);
  assign retire     = (response_id != prev_response_id) && eot_mem[prev_response_id];
  assign eot        = eot_mem[response_id];
  assign sync_id    = 1'b0;

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (issue && last_burst) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state                    <= IDLE;
      enabled                  <= 1'b0;
      request_id               <= '0;
      remaining                <= '0;
      dm_req_valid             <= 1'b0;
      dm_req_last_burst_length <= '0;
      prev_response_id         <= '0;
      xfer_done                <= 1'b0;
      // NOTE: the flag memory is reset explicitly; stale eot flags would otherwise fire bogus completions.
      eot_mem                  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every update sees pre-edge values.
      state            <= state_next;
      prev_response_id <= response_id;
      xfer_done        <= retire;

      if (enable)
        enabled <= 1'b1;
      else if (state == IDLE && request_id == response_id)
        enabled <= 1'b0;

      if (accept) begin
        dm_req_valid             <= 1'b1;
        dm_req_last_burst_length <= req_last_burst_length;
        remaining                <= req_burst_count;
      end else begin
        if (dm_req_ready) dm_req_valid <= 1'b0;
        if (issue) remaining <= remaining - C_BURSTS_WIDTH'(1);
      end

      // Retire clears first; a same-cycle issue to that slot is written later and wins.
      if (retire) eot_mem[prev_response_id] <= 1'b0;
      if (issue) begin
        eot_mem[request_id] <= last_burst;
        request_id          <= next_id;
      end
    end
  end

endmodule
